// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the binary<->BCD conversion paths.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SHIFT = 2'd2
  } state_e;

  localparam int BCD_NIB = 4;

  function automatic logic is_bcd_valid(input logic [BCD_NIB-1:0] nibble);
    return nibble <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_nib_adj.sv
// Reverse double-dabble digit correction: a nibble that reached 8+ after a right
// shift carried a ten's worth of weight from above, so pull 3 back out.
module bcd_nib_adj
  import bcd_pkg::*;
(
  input  logic [BCD_NIB-1:0] nib_i,
  output logic [BCD_NIB-1:0] nib_o
);

  assign nib_o = (nib_i >= 4'd8) ? (nib_i - 4'd3) : nib_i;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential reverse double-dabble converter: packed BCD digits -> unsigned binary,
// one shift per clock, with a start/busy/done handshake.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [BCD_NIB*DIGITS-1:0] bcd_in,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [BIN_W-1:0]          bin_out,
  output state_e                    state_o
);

  localparam int BCD_W = BCD_NIB * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);

  if ((64'd1 << BIN_W) < 64'(10 ** DIGITS)) begin : g_width_check
    $error("bcd_to_bin_seq: BIN_W too small to hold 10**DIGITS - 1");
  end

  // Handshake: start is sampled only in IDLE together with bcd_in; busy covers the
  // whole conversion; done is a one-cycle pulse on which bin_out/err become valid.
  // A start presented in the done cycle is accepted because the FSM is already IDLE.
  state_e             state_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BIN_W-1:0]   bin_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [BIN_W-1:0]   bin_out_q;

  logic [BCD_W-1:0]   bcd_sh;
  logic [BCD_W-1:0]   bcd_d;
  logic [BIN_W-1:0]   bin_d;
  logic               all_valid;

  // The BCD LSB falls into the binary MSB on every shift.
  assign bcd_sh = {1'b0, bcd_q[BCD_W-1:1]};
  assign bin_d  = {bcd_q[0], bin_q[BIN_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_nib_adj u_adj (
      .nib_i (bcd_sh[g*BCD_NIB +: BCD_NIB]),
      .nib_o (bcd_d[g*BCD_NIB +: BCD_NIB])
    );
  end

  always_comb begin
    all_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd_valid(bcd_q[i*BCD_NIB +: BCD_NIB])) all_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      bin_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bcd_q   <= bcd_in;
            bin_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (!all_valid) begin
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            bin_out_q <= '0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BIN_W - 1)) begin
            bin_out_q <= bin_d;
            done_q    <= 1'b1;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign bin_out = bin_out_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: directed scenarios plus a random sweep
// against a decimal-arithmetic reference model.
module tb_bcd_to_bin_seq;
  import bcd_pkg::*;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int W      = 4 * DIGITS;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [W-1:0]     bcd_in = '0;
  logic             busy;
  logic             done;
  logic             err;
  logic [BIN_W-1:0] bin_out;
  state_e           dbg_state;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;
  logic [BIN_W:0] exp_q[$];
  logic done_prev = 1'b0;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .bin_out (bin_out),
    .state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: value = sum(digit_i * 10^i); any digit above 9 flags an error with 0.
  function automatic logic [BIN_W:0] model(input logic [W-1:0] v);
    logic [W-1:0] t;
    int sum;
    bit bad;
    int d;
    t = v;
    sum = 0;
    bad = 0;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(t[4*i +: 4]);
      if (d > 9) bad = 1;
      sum += d * (10 ** i);
    end
    return bad ? {1'b1, {BIN_W{1'b0}}} : {1'b0, BIN_W'(sum)};
  endfunction

  function automatic logic [W-1:0] to_bcd(input int n);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = n;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Protocol monitor: busy and done never overlap, done lasts exactly one cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy_done_excl", 32'(busy && done), 32'd0);
      chk("done_width", 32'(done && done_prev), 32'd0);
    end
    done_prev = rst_n ? done : 1'b0;
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [W-1:0] v);
    start  = 1'b1;
    bcd_in = v;
    exp_q.push_back(model(v));
  endtask

  // Steps from the start edge to done; optionally re-pulses start after inject_at edges.
  task automatic finish_conv(input int inject_at, input logic [W-1:0] inject_val);
    logic [BIN_W:0] e;
    int edges;
    int bcnt;
    @(posedge clk); #1;
    edges  = 1;
    start  = 1'b0;
    bcd_in = W'($urandom);
    chk("busy_after_start", 32'(busy), 32'd1);
    bcnt = busy ? 1 : 0;
    while (!done && edges < 40) begin
      if (inject_at != 0 && edges == inject_at) begin
        start  = 1'b1;
        bcd_in = inject_val;
      end
      @(posedge clk); #1;
      edges++;
      start = 1'b0;
      if (busy) bcnt++;
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    chk("done_seen", 32'(done), 32'd1);
    chk("latency_edges", 32'(edges), e[BIN_W] ? 32'd2 : 32'd16);
    chk("busy_cycles", 32'(bcnt), e[BIN_W] ? 32'd1 : 32'd15);
    chk("bin_out", 32'(bin_out), 32'(e[BIN_W-1:0]));
    chk("err", 32'(err), 32'(e[BIN_W]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] v;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_bin_out", 32'(bin_out), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(16'h0000); finish_conv(0, '0);
    issue(16'h9999); finish_conv(0, '0);

    // Back-to-back: second start is presented in the done cycle.
    issue(16'h1234); finish_conv(0, '0);
    issue(16'h0042); finish_conv(0, '0);

    issue(16'h12A4); finish_conv(0, '0);
    issue(16'h0001); finish_conv(0, '0);

    // Start while busy must be ignored.
    issue(16'h0808); finish_conv(5, 16'h5555);
    repeat (3) begin
      @(posedge clk); #1;
      chk("bin_out_hold", 32'(bin_out), 32'd808);
      chk("state_idle", 32'(dbg_state), 32'(IDLE));
    end

    // Reset mid-SHIFT abandons the conversion without a done pulse.
    issue(16'h3456);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    chk("mid_state_shift", 32'(dbg_state), 32'(SHIFT));
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_bin_out", 32'(bin_out), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'(IDLE));
    void'(exp_q.pop_front());
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      chk("no_done_after_rst", 32'(done), 32'd0);
    end
    issue(16'h0007); finish_conv(0, '0);

    // Random sweep, mostly legal values with occasional raw (possibly illegal) words.
    repeat (60) begin
      if ($urandom_range(0, 7) == 0) v = W'($urandom);
      else v = to_bcd(int'($urandom_range(0, 9999)));
      issue(v);
      finish_conv(0, '0);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    // ---------------- final report ----------------
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
